// File: rtl/axi_node_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_node_pkg
//  Description : Shared AXI node definitions: response codes and the
//                write-error responder state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_node_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN_W = 2'd1,
        SEND_B  = 2'd2
    } err_state_t;

endpackage : axi_node_pkg
`default_nettype wire

// File: rtl/axi_outstanding_counter.sv
`default_nettype none
// ============================================================================
//  Module      : axi_outstanding_counter
//  Description : Saturating up/down counter of outstanding normal writes for
//                one master. Flags full and nonzero from the registered count.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_outstanding_counter #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic incr,
    input  logic decr,
    output logic full,
    output logic nonzero
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_OUTSTANDING);

    logic [CNT_WIDTH-1:0] count;

    // Count up on a forwarded AW, down on a delivered B; simultaneous events
    // cancel. The count never wraps in either direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (incr && !decr) begin
            if (count != CNT_MAX) begin
                count <= count + CNT_WIDTH'(1);
            end
        end else if (decr && !incr) begin
            if (count != '0) begin
                count <= count - CNT_WIDTH'(1);
            end
        end
    end

    assign full    = (count == CNT_MAX);
    assign nonzero = (count != '0);

`ifndef SYNTHESIS
    // Flag increments past the limit and decrements below zero.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(incr && !decr && count == CNT_MAX))
                else $warning("outstanding counter overflow, saturating");
            assert (!(decr && !incr && count == '0))
                else $warning("outstanding counter underflow, holding zero");
        end
    end
`endif

endmodule : axi_outstanding_counter
`default_nettype wire

// File: rtl/axi_write_error_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axi_write_error_responder
//  Description : Terminates a write burst that decoded to no slave: captures
//                the AW ID/USER, sinks all W beats and returns one DECERR B.
//                Also hosts the per-master outstanding-write counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_write_error_responder
    import axi_node_pkg::*;
#(
    parameter int ID_WIDTH        = 4,
    parameter int USER_WIDTH      = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sample_awdata_info_i,
    input  logic [ID_WIDTH-1:0]   awid_i,
    input  logic [USER_WIDTH-1:0] awuser_i,
    input  logic                  handle_error_i,
    input  logic                  wvalid_i,
    input  logic                  wlast_i,
    output logic                  wready_o,
    output logic                  wdata_error_completed_o,
    input  logic                  error_req_i,
    output logic                  error_gnt_o,
    output logic                  bvalid_o,
    input  logic                  bready_i,
    output logic [ID_WIDTH-1:0]   bid_o,
    output logic [USER_WIDTH-1:0] buser_o,
    output logic [1:0]            bresp_o,
    input  logic                  incr_req_i,
    input  logic                  decr_req_i,
    output logic                  full_counter_o,
    output logic                  outstanding_trans_o
);

    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

    err_state_t            state;
    logic [ID_WIDTH-1:0]   id_q;
    logic [USER_WIDTH-1:0] user_q;
    logic                  last_beat;
    logic                  b_handshake;

    assign last_beat   = (state == DRAIN_W) && wvalid_i && wlast_i;
    assign b_handshake = (state == SEND_B) && error_req_i && bready_i;

    // Error FSM plus ID/USER capture; capture is only honoured while idle so
    // the pending response keeps the ID of the failing AW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            id_q   <= '0;
            user_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_awdata_info_i) begin
                        id_q   <= awid_i;
                        user_q <= awuser_i;
                    end
                    if (handle_error_i) begin
                        state <= DRAIN_W;
                    end
                end
                DRAIN_W: begin
                    if (last_beat) begin
                        state <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (b_handshake) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Every beat is accepted while draining; data is discarded.
    assign wready_o                = (state == DRAIN_W);
    assign wdata_error_completed_o = last_beat;

    // bvalid depends only on state and the decoder request, never on bready.
    assign bvalid_o    = (state == SEND_B) && error_req_i;
    assign error_gnt_o = b_handshake;
    assign bid_o       = id_q;
    assign buser_o     = user_q;
    assign bresp_o     = RESP_DECERR;

    axi_outstanding_counter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_outstanding_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .incr    (incr_req_i),
        .decr    (decr_req_i),
        .full    (full_counter_o),
        .nonzero (outstanding_trans_o)
    );

`ifndef SYNTHESIS
    // The decoder must hold handle_error until the drain finishes.
    always_ff @(posedge clk) begin
        if (rst_n && state == DRAIN_W) begin
            assert (handle_error_i)
                else $warning("handle_error dropped while draining W");
        end
    end
`endif

endmodule : axi_write_error_responder
`default_nettype wire

// File: tb/tb_axi_write_error_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_write_error_responder
//  Description : Directed scoreboard bench for the write error responder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_write_error_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_awdata_info_i = 1'b0;
    logic [3:0] awid_i = '0;
    logic [3:0] awuser_i = '0;
    logic       handle_error_i = 1'b0;
    logic       wvalid_i = 1'b0;
    logic       wlast_i = 1'b0;
    logic       wready_o;
    logic       wdata_error_completed_o;
    logic       error_req_i = 1'b0;
    logic       error_gnt_o;
    logic       bvalid_o;
    logic       bready_i = 1'b0;
    logic [3:0] bid_o;
    logic [3:0] buser_o;
    logic [1:0] bresp_o;
    logic       incr_req_i = 1'b0;
    logic       decr_req_i = 1'b0;
    logic       full_counter_o;
    logic       outstanding_trans_o;

    int tests = 0;
    int fails = 0;

    logic       exp_w[$];
    logic [7:0] exp_b[$];

    axi_write_error_responder #(
        .ID_WIDTH        (4),
        .USER_WIDTH      (4),
        .MAX_OUTSTANDING (8)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .sample_awdata_info_i    (sample_awdata_info_i),
        .awid_i                  (awid_i),
        .awuser_i                (awuser_i),
        .handle_error_i          (handle_error_i),
        .wvalid_i                (wvalid_i),
        .wlast_i                 (wlast_i),
        .wready_o                (wready_o),
        .wdata_error_completed_o (wdata_error_completed_o),
        .error_req_i             (error_req_i),
        .error_gnt_o             (error_gnt_o),
        .bvalid_o                (bvalid_o),
        .bready_i                (bready_i),
        .bid_o                   (bid_o),
        .buser_o                 (buser_o),
        .bresp_o                 (bresp_o),
        .incr_req_i              (incr_req_i),
        .decr_req_i              (decr_req_i),
        .full_counter_o          (full_counter_o),
        .outstanding_trans_o     (outstanding_trans_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expected results whenever the DUT completes a W beat or a B.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wready_o && wvalid_i) begin
                if (exp_w.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL w_unexpected: beat accepted with nothing expected");
                end else begin
                    check("w_completed", wdata_error_completed_o, exp_w.pop_front());
                end
            end
            if (bvalid_o && bready_i) begin
                if (exp_b.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL b_unexpected: B handshake with nothing expected");
                end else begin
                    logic [7:0] e;
                    e = exp_b.pop_front();
                    check("b_id", bid_o, e[7:4]);
                    check("b_user", buser_o, e[3:0]);
                    check("b_resp", bresp_o, 2'b11);
                    check("b_gnt", error_gnt_o, 1'b1);
                end
            end
            if (bvalid_o && !bready_i) begin
                check("b_gnt_held", error_gnt_o, 1'b0);
            end
        end
    end

    // One full error transaction: capture+handle, W drain pattern, B pattern.
    task automatic run_error(input logic [3:0] id, input logic [3:0] user,
                             input int nb, input logic [7:0] vv, input logic [7:0] ll,
                             input int nr, input logic [7:0] rq, input logic [7:0] rd);
        tick();
        sample_awdata_info_i = 1'b1;
        awid_i = id;
        awuser_i = user;
        handle_error_i = 1'b1;
        wvalid_i = 1'b0;
        wlast_i = 1'b0;
        error_req_i = 1'b0;
        bready_i = 1'b0;
        @(negedge clk);
        check("idle_wready", wready_o, 1'b0);
        for (int i = 0; i < nb; i++) begin
            tick();
            awid_i = id ^ 4'hF;
            awuser_i = user ^ 4'hF;
            wvalid_i = vv[i];
            wlast_i = ll[i];
            if (vv[i]) exp_w.push_back(ll[i]);
            @(negedge clk);
            check("drain_wready", wready_o, 1'b1);
            check("drain_completed", wdata_error_completed_o, vv[i] & ll[i]);
            check("drain_bvalid", bvalid_o, 1'b0);
        end
        for (int j = 0; j < nr; j++) begin
            tick();
            handle_error_i = 1'b0;
            wvalid_i = 1'b0;
            wlast_i = 1'b0;
            error_req_i = rq[j];
            bready_i = rd[j];
            if (rq[j] && rd[j]) exp_b.push_back({id, user});
            @(negedge clk);
            check("sendb_bvalid", bvalid_o, rq[j]);
            check("sendb_gnt", error_gnt_o, rq[j] & rd[j]);
            check("sendb_wready", wready_o, 1'b0);
        end
    endtask

    // Cycle after a grant: a still-high request must not produce a B.
    task automatic idle_check();
        tick();
        sample_awdata_info_i = 1'b0;
        handle_error_i = 1'b0;
        error_req_i = 1'b1;
        bready_i = 1'b1;
        @(negedge clk);
        check("post_gnt_bvalid", bvalid_o, 1'b0);
        check("post_gnt_wready", wready_o, 1'b0);
        tick();
        error_req_i = 1'b0;
        bready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_wready", wready_o, 1'b0);
        check("rst_bvalid", bvalid_o, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_completed", wdata_error_completed_o, 1'b0);
        check("rst_gnt", error_gnt_o, 1'b0);
        check("rst_bid", bid_o, 4'h0);
        check("rst_buser", buser_o, 4'h0);
        check("rst_bresp", bresp_o, 2'b11);
        check("rst_full", full_counter_o, 1'b0);
        check("rst_outstanding", outstanding_trans_o, 1'b0);

        // Single error, 4 beats, immediate bready.
        run_error(4'h5, 4'h3, 4, 8'b0000_1111, 8'b0000_1000, 1, 8'b1, 8'b1);
        idle_check();
        // B backpressure: bready low for 3 cycles.
        run_error(4'h6, 4'h1, 1, 8'b1, 8'b1, 4, 8'b1111, 8'b1000);
        idle_check();
        // W gaps, incl. wlast without wvalid; bready without error_req.
        run_error(4'h9, 4'h2, 4, 8'b1001, 8'b1010, 2, 8'b10, 8'b11);
        idle_check();
        // Back-to-back: second burst starts the cycle after the first grant.
        run_error(4'h7, 4'hC, 2, 8'b11, 8'b10, 1, 8'b1, 8'b1);
        run_error(4'hA, 4'h5, 2, 8'b11, 8'b10, 1, 8'b1, 8'b1);
        idle_check();

        // Counter: fill, overflow, simultaneous, drain, underflow.
        for (int i = 0; i < 8; i++) begin
            tick();
            incr_req_i = 1'b1;
            @(negedge clk);
            check("cnt_fill_full", full_counter_o, 1'b0);
            check("cnt_fill_nz", outstanding_trans_o, (i != 0) ? 1'b1 : 1'b0);
        end
        tick();
        incr_req_i = 1'b1;
        @(negedge clk);
        check("cnt_full_after8", full_counter_o, 1'b1);
        tick();
        incr_req_i = 1'b1;
        decr_req_i = 1'b1;
        @(negedge clk);
        check("cnt_saturated", full_counter_o, 1'b1);
        for (int d = 0; d < 8; d++) begin
            tick();
            incr_req_i = 1'b0;
            decr_req_i = 1'b1;
            @(negedge clk);
            check("cnt_drain_full", full_counter_o, (d == 0) ? 1'b1 : 1'b0);
            check("cnt_drain_nz", outstanding_trans_o, 1'b1);
        end
        tick();
        decr_req_i = 1'b0;
        @(negedge clk);
        check("cnt_empty_nz", outstanding_trans_o, 1'b0);
        check("cnt_empty_full", full_counter_o, 1'b0);
        tick();
        decr_req_i = 1'b1;
        tick();
        decr_req_i = 1'b0;
        @(negedge clk);
        check("cnt_underflow_nz", outstanding_trans_o, 1'b0);
        check("cnt_underflow_full", full_counter_o, 1'b0);

        // Reset while a B is pending.
        tick();
        incr_req_i = 1'b1;
        tick();
        incr_req_i = 1'b0;
        sample_awdata_info_i = 1'b1;
        awid_i = 4'h3;
        awuser_i = 4'h4;
        handle_error_i = 1'b1;
        tick();
        sample_awdata_info_i = 1'b0;
        wvalid_i = 1'b1;
        wlast_i = 1'b1;
        exp_w.push_back(1'b1);
        tick();
        handle_error_i = 1'b0;
        wvalid_i = 1'b0;
        wlast_i = 1'b0;
        error_req_i = 1'b1;
        bready_i = 1'b0;
        @(negedge clk);
        check("pre_rst_bvalid", bvalid_o, 1'b1);
        check("pre_rst_nz", outstanding_trans_o, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        check("async_rst_bvalid", bvalid_o, 1'b0);
        check("async_rst_nz", outstanding_trans_o, 1'b0);
        check("async_rst_bid", bid_o, 4'h0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_bvalid", bvalid_o, 1'b0);
        check("post_rst_wready", wready_o, 1'b0);
        tick();
        error_req_i = 1'b0;
        tick();

        check("exp_w_empty", exp_w.size(), 0);
        check("exp_b_empty", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_axi_write_error_responder
`default_nettype wire

// File: doc/axi_write_error_responder.md
Name: axi_write_error_responder

Overview:
Slave-side companion to the write-address decoder of the AXI node. It terminates a write burst that decoded to no reachable slave:
- samples the failing AW's ID/USER;
- sinks the burst's W beats;
- returns a single B response with DECERR.
It also holds the per-master outstanding-write counter that gates the decoder's error handling.

Parameters:
ID_WIDTH, 4, AXI ID width.
USER_WIDTH, 4, AXI user width.
MAX_OUTSTANDING, 8, max outstanding normal writes per master (>=1).
CNT_WIDTH, $clog2(MAX_OUTSTANDING+1), counter width (derived; not overridden).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
sample_awdata_info_i  in  1  capture awid_i/awuser_i this cycle
awid_i  in  ID_WIDTH  AW ID of the failing transaction
awuser_i  in  USER_WIDTH  AW user of the failing transaction
handle_error_i  in  1  decoder is in W-drain phase
wvalid_i  in  1  master W valid
wlast_i  in  1  master W last
wready_o  out  1  W ready during drain
wdata_error_completed_o  out  1  last error W beat accepted
error_req_i  in  1  decoder requests error B
error_gnt_o  out  1  error B handshake done
bvalid_o  out  1  error B valid (to node B mux)
bready_i  in  1  master B ready
bid_o  out  ID_WIDTH  sampled ID
buser_o  out  USER_WIDTH  sampled user
bresp_o  out  2  response code, fixed DECERR
incr_req_i  in  1  normal AW forwarded to a slave
decr_req_i  in  1  normal B delivered to master
full_counter_o  out  1  counter == MAX_OUTSTANDING
outstanding_trans_o  out  1  counter != 0

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE; counter=0; id_q=0; user_q=0.
  - Resulting outputs: wready_o=0, wdata_error_completed_o=0, bvalid_o=0, error_gnt_o=0, bid_o=0, buser_o=0, full_counter_o=0, outstanding_trans_o=0.
  - bresp_o=2'b11 always.
  - Reset mid-drain or mid-response abandons the transaction silently.
- Capture: in IDLE, sample_awdata_info_i=1 loads id_q/user_q on the edge. Ignored in other states; the registers hold value.
- FSM states: IDLE, DRAIN_W, SEND_B.
  - IDLE -> DRAIN_W when handle_error_i=1.
  - DRAIN_W:
    - wready_o=1.
    - wdata_error_completed_o = wvalid_i & wlast_i (combinational, same cycle as the last beat).
    - On that beat -> SEND_B. Non-last beats are dropped; no beat limit.
    - handle_error_i dropping in DRAIN_W is a protocol violation: assertion, FSM stays.
  - SEND_B:
    - bvalid_o = error_req_i; bid_o=id_q; buser_o=user_q.
    - error_gnt_o = error_req_i & bready_i.
    - On grant -> IDLE.
    - bready_i with error_req_i=0 produces no handshake.
- Timing:
  - Earliest error B handshake: 1 cycle after the wlast beat (the decoder raises error_req the next cycle).
  - Back-to-back errors: IDLE is re-entered the cycle after the grant, so the next handle_error_i is accepted then.
- Outputs outside their state: wready_o=0, bvalid_o=0, error_gnt_o=0.
- Counter:
  - Registered. incr only: +1. decr only: -1. Both in one cycle: unchanged.
  - incr at MAX_OUTSTANDING: saturate, assertion fires.
  - decr at 0: hold 0, assertion fires.
  - full_counter_o and outstanding_trans_o are decoded combinationally from the registered counter, so they update one cycle after the event.
  - The counter is independent of the FSM.
- No combinational path from bready_i to bvalid_o.

Decomposition:
- Package axi_node_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR constants; err_state_t enum {IDLE, DRAIN_W, SEND_B}.
- Sub-module axi_outstanding_counter (parameters MAX_OUTSTANDING, CNT_WIDTH; ports incr, decr, full, nonzero).
- FSM and capture registers live in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-SEND_B -> bvalid_o=0 and counter=0 immediately; after release the FSM is in IDLE.
- Single error: sample id=0x5/user=0x3; handle_error; send 4 beats with wlast on the 4th -> wready_o=1 for all 4, completed pulse on the 4th only. error_req with bready=1 -> bvalid=1, bid=0x5, buser=0x3, bresp=2'b11, gnt for 1 cycle, IDLE next cycle.
- B backpressure: error_req=1, bready=0 for 3 cycles, then 1 -> bvalid held for 4 cycles, gnt only in the 4th.
- W gaps: in DRAIN_W, wvalid pattern 1,0,0,1(last) -> completed only in the 4th cycle; state is SEND_B the cycle after.
- Counter: 8 incr -> full_counter_o=1 after the 8th. A further incr -> stays 8, assertion. incr+decr together -> 8. 8 decr -> outstanding_trans_o=0.
- Back-to-back errors: second handle_error the cycle after the first gnt -> second burst drained, and its B carries the newly sampled ID 0xA.
